piece_controller: RTL and testbench

PIECE_CONTROLLER -- requirements
Module: piece_controller

---
 rtl/piece_controller.sv | 267 ++++++++++++++++++++++++++
 tb/tb_piece_controller.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_controller.sv
// piece_controller
//   Falling-piece controller for a block-stacking game. Holds the active
//   piece as an origin plus four 2-bit cell offsets. It spawns pieces,
//   applies one key or gravity action per video frame, and publishes the
//   current, previous and candidate cell positions to the board logic.
//
// Ports
//   Clk, Reset              system clock, synchronous active-high reset
//   frame_clk_rising_edge   one-Clk pulse per 60 Hz frame
//   key_*                   level-sensitive keys (rotations/moves edge-detected per frame)
//   next_piece              piece type from the random generator (7 aliases to 0)
//   can_move                legality flags [4] left [3] right [2] rot_r [1] rot_l [0] down
//   BOARD_BUSY              board is clearing/dropping lines; freezes the controller
//   x_block, y_block        current cells, 4 x 5-bit fields, cell0 in [19:15]
//   save_xblock/yblock      cells before the last change (equal to current otherwise)
//   x/y_move_*, x/y_rotate_* candidate cells for each action
//   get_new_block           one-Clk pulse when a new piece is placed
//   block                   color of the current piece (EMPTY after reset)
//   game_over               sticky game-over flag

package piece_controller_pkg;
    typedef enum logic [2:0] {
        EMPTY   = 3'd0,
        COLOR_I = 3'd1,
        COLOR_O = 3'd2,
        COLOR_T = 3'd3,
        COLOR_S = 3'd4,
        COLOR_Z = 3'd5,
        COLOR_J = 3'd6,
        COLOR_L = 3'd7
    } block_color;
endpackage

module piece_controller
    import piece_controller_pkg::*;
#(
    parameter int unsigned GRAVITY_FRAMES = 30,
    parameter int unsigned SPAWN_X        = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk_rising_edge,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_rot_l,
    input  logic        key_rot_r,
    input  logic        key_down,
    input  logic [2:0]  next_piece,
    input  logic [4:0]  can_move,
    input  logic        BOARD_BUSY,
    output logic [19:0] x_block,
    output logic [19:0] y_block,
    output logic [19:0] save_xblock,
    output logic [19:0] save_yblock,
    output logic [19:0] x_move_left,
    output logic [19:0] y_move_left,
    output logic [19:0] x_move_right,
    output logic [19:0] y_move_right,
    output logic [19:0] x_move_down,
    output logic [19:0] y_move_down,
    output logic [19:0] x_rotate_left,
    output logic [19:0] y_rotate_left,
    output logic [19:0] x_rotate_right,
    output logic [19:0] y_rotate_right,
    output logic        get_new_block,
    output block_color  block,
    output logic        game_over
);

    typedef enum logic [1:0] {SPAWN, FALL, GAME_OVER} state_t;
    typedef logic [3:0][1:0] offs_t;   // element [i] is the offset of cell i

    localparam int unsigned   CW        = (GRAVITY_FRAMES > 1) ? $clog2(GRAVITY_FRAMES) : 1;
    localparam logic [CW-1:0] GRAV_LAST = CW'(GRAVITY_FRAMES - 1);

    state_t     state_q, state_d;
    logic [4:0] px_q, px_d, py_q, py_d;
    offs_t      dx_q, dx_d, dy_q, dy_d;
    logic [2:0] type_q, type_d;
    logic [1:0] orient_q, orient_d;
    block_color color_q, color_d;
    logic [CW-1:0] grav_q, grav_d;
    logic [3:0] hist_q, hist_d;        // {rot_r, rot_l, left, right} at last eligible frame
    logic       get_new_q, get_new_d;
    logic [19:0] save_x_q, save_y_q;

    // Per-cell origin + offset, mod 32; cell0 lands in the top field.
    function automatic logic [19:0] cells(input logic [4:0] org, input offs_t d);
        logic [19:0] r;
        r = '0;
        for (int unsigned i = 0; i < 4; i++)
            r = {r[14:0], 5'(org + {3'b000, d[i]})};
        return r;
    endfunction

    function automatic offs_t mk(input logic [1:0] c0, input logic [1:0] c1,
                                 input logic [1:0] c2, input logic [1:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    function automatic offs_t spawn_dx(input logic [2:0] t);
        case (t)
            3'd1:    return mk(2'd1, 2'd2, 2'd1, 2'd2);
            3'd2:    return mk(2'd1, 2'd0, 2'd1, 2'd2);
            3'd3:    return mk(2'd1, 2'd2, 2'd0, 2'd1);
            3'd4:    return mk(2'd0, 2'd1, 2'd1, 2'd2);
            3'd5:    return mk(2'd0, 2'd0, 2'd1, 2'd2);
            3'd6:    return mk(2'd2, 2'd0, 2'd1, 2'd2);
            default: return mk(2'd0, 2'd1, 2'd2, 2'd3);
        endcase
    endfunction

    function automatic offs_t spawn_dy(input logic [2:0] t);
        case (t)
            3'd1, 3'd3, 3'd4: return mk(2'd0, 2'd0, 2'd1, 2'd1);
            3'd2, 3'd5, 3'd6: return mk(2'd0, 2'd1, 2'd1, 2'd1);
            default:          return mk(2'd1, 2'd1, 2'd1, 2'd1);
        endcase
    endfunction

    // Rotated offsets; the O piece rotates onto itself.
    offs_t      rr_dx, rr_dy, rl_dx, rl_dy;
    logic [1:0] bound;
    always_comb begin
        bound = (type_q == 3'd0) ? 2'd3 : 2'd2;
        rr_dx = dx_q;
        rr_dy = dy_q;
        rl_dx = dx_q;
        rl_dy = dy_q;
        if (type_q != 3'd1) begin
            for (int unsigned i = 0; i < 4; i++) begin
                rr_dx[i] = bound - dy_q[i];
                rr_dy[i] = dx_q[i];
                rl_dx[i] = dy_q[i];
                rl_dy[i] = bound - dx_q[i];
            end
        end
    end

    logic loaded;
    assign loaded = (color_q != EMPTY);

    assign x_block        = cells(px_q, dx_q);
    assign y_block        = cells(py_q, dy_q);
    assign x_move_left    = loaded ? cells(px_q - 5'd1, dx_q) : '0;
    assign y_move_left    = loaded ? cells(py_q, dy_q)        : '0;
    assign x_move_right   = loaded ? cells(px_q + 5'd1, dx_q) : '0;
    assign y_move_right   = loaded ? cells(py_q, dy_q)        : '0;
    assign x_move_down    = loaded ? cells(px_q, dx_q)        : '0;
    assign y_move_down    = loaded ? cells(py_q + 5'd1, dy_q) : '0;
    assign x_rotate_right = loaded ? cells(px_q, rr_dx)       : '0;
    assign y_rotate_right = loaded ? cells(py_q, rr_dy)       : '0;
    assign x_rotate_left  = loaded ? cells(px_q, rl_dx)       : '0;
    assign y_rotate_left  = loaded ? cells(py_q, rl_dy)       : '0;

    // The save outputs are a one-cycle-delayed copy of the current cells,
    // so they differ only in the cycle right after a change.
    assign save_xblock   = save_x_q;
    assign save_yblock   = save_y_q;
    assign get_new_block = get_new_q;
    assign block         = color_q;
    assign game_over     = (state_q == GAME_OVER);

    logic       eligible, grav_req, down_req;
    logic [3:0] keys, edges;

    always_comb begin
        state_d   = state_q;
        px_d      = px_q;
        py_d      = py_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        type_d    = type_q;
        orient_d  = orient_q;
        color_d   = color_q;
        grav_d    = grav_q;
        hist_d    = hist_q;
        get_new_d = 1'b0;

        eligible = frame_clk_rising_edge && !BOARD_BUSY;
        keys     = {key_rot_r, key_rot_l, key_left, key_right};
        edges    = keys & ~hist_q;
        grav_req = (grav_q == GRAV_LAST);
        down_req = key_down || grav_req;

        case (state_q)
            SPAWN: begin
                if (eligible) begin
                    type_d    = (next_piece == 3'd7) ? 3'd0 : next_piece;
                    px_d      = 5'(SPAWN_X);
                    py_d      = '0;
                    dx_d      = spawn_dx(type_d);
                    dy_d      = spawn_dy(type_d);
                    orient_d  = '0;
                    color_d   = block_color'(type_d + 3'd1);
                    get_new_d = 1'b1;
                    grav_d    = '0;
                    hist_d    = keys;
                    state_d   = FALL;
                end
            end
            FALL: begin
                if (eligible) begin
                    hist_d = keys;
                    // A pending gravity request is held while a key action wins the frame.
                    grav_d = grav_req ? grav_q : grav_q + CW'(1);
                    if (edges[3]) begin
                        if (can_move[2]) begin
                            dx_d     = rr_dx;
                            dy_d     = rr_dy;
                            orient_d = orient_q + 2'd1;
                        end
                    end else if (edges[2]) begin
                        if (can_move[1]) begin
                            dx_d     = rl_dx;
                            dy_d     = rl_dy;
                            orient_d = orient_q - 2'd1;
                        end
                    end else if (edges[1]) begin
                        if (can_move[4]) px_d = px_q - 5'd1;
                    end else if (edges[0]) begin
                        if (can_move[3]) px_d = px_q + 5'd1;
                    end else if (down_req) begin
                        grav_d = '0;
                        if (can_move[0]) py_d = py_q + 5'd1;
                        else             state_d = (py_q == '0) ? GAME_OVER : SPAWN;
                    end
                end
            end
            GAME_OVER: ;
            default: state_d = SPAWN;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= SPAWN;
            px_q      <= '0;
            py_q      <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            type_q    <= '0;
            orient_q  <= '0;
            color_q   <= EMPTY;
            grav_q    <= '0;
            hist_q    <= '0;
            get_new_q <= 1'b0;
            save_x_q  <= '0;
            save_y_q  <= '0;
        end else begin
            state_q   <= state_d;
            px_q      <= px_d;
            py_q      <= py_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            type_q    <= type_d;
            orient_q  <= orient_d;
            color_q   <= color_d;
            grav_q    <= grav_d;
            hist_q    <= hist_d;
            get_new_q <= get_new_d;
            save_x_q  <= x_block;
            save_y_q  <= y_block;
        end
    end

endmodule

// File: tb/tb_piece_controller.sv
// Testbench for piece_controller: a directed vector table, hand-written
// gravity/lock/game-over sequences, then randomized stimulus checked
// against a behavioural model of the piece rules.
module tb_piece_controller;
    import piece_controller_pkg::*;

    localparam int G  = 30;
    localparam int SX = 3;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic frame = 1'b0, kl = 1'b0, kr = 1'b0, krl = 1'b0, krr = 1'b0, kd = 1'b0;
    logic [2:0] np = 3'd0;
    logic [4:0] cm = 5'b11111;
    logic busy = 1'b0;

    logic [19:0] xb, yb, sxb, syb, xml, yml, xmr, ymr, xmd, ymd, xrl, yrl, xrr, yrr;
    logic gnb, gov;
    block_color blk;

    piece_controller #(.GRAVITY_FRAMES(G), .SPAWN_X(SX)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk_rising_edge(frame),
        .key_left(kl), .key_right(kr), .key_rot_l(krl), .key_rot_r(krr), .key_down(kd),
        .next_piece(np), .can_move(cm), .BOARD_BUSY(busy),
        .x_block(xb), .y_block(yb), .save_xblock(sxb), .save_yblock(syb),
        .x_move_left(xml), .y_move_left(yml), .x_move_right(xmr), .y_move_right(ymr),
        .x_move_down(xmd), .y_move_down(ymd), .x_rotate_left(xrl), .y_rotate_left(yrl),
        .x_rotate_right(xrr), .y_rotate_right(yrr),
        .get_new_block(gnb), .block(blk), .game_over(gov)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic chk20(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    function automatic logic [19:0] pk4(input int a, input int b, input int c, input int d);
        return {5'(a), 5'(b), 5'(c), 5'(d)};
    endfunction

    // ---------------- behavioural model ----------------
    int SDX[7][4] = '{'{0,1,2,3}, '{1,2,1,2}, '{1,0,1,2}, '{1,2,0,1},
                      '{0,1,1,2}, '{0,0,1,2}, '{2,0,1,2}};
    int SDY[7][4] = '{'{1,1,1,1}, '{0,0,1,1}, '{0,1,1,1}, '{0,0,1,1},
                      '{0,0,1,1}, '{0,1,1,1}, '{0,1,1,1}};

    bit m_wait, m_over, m_loaded, m_gnb;
    int m_px, m_py, m_type, m_g;
    int m_dx[4], m_dy[4];
    bit m_h[4];
    logic [19:0] m_sx, m_sy;

    function automatic logic [19:0] mcells(input int org, input int d[4]);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r = {r[14:0], 5'((org + d[i]) % 32)};
        return r;
    endfunction

    function automatic void rotated(input bit right, output int nx[4], output int ny[4]);
        int b;
        b = (m_type == 0) ? 3 : 2;
        for (int i = 0; i < 4; i++) begin
            if (m_type == 1) begin
                nx[i] = m_dx[i]; ny[i] = m_dy[i];
            end else if (right) begin
                nx[i] = (b - m_dy[i] + 4) % 4; ny[i] = m_dx[i];
            end else begin
                nx[i] = m_dy[i]; ny[i] = (b - m_dx[i] + 4) % 4;
            end
        end
    endfunction

    task automatic model_step();
        bit keys[4];
        bit edg[4];
        int act;
        bit grav;
        int nx[4], ny[4];
        if (Reset) begin
            m_wait = 1; m_over = 0; m_loaded = 0; m_gnb = 0;
            m_px = 0; m_py = 0; m_type = 0; m_g = 0;
            for (int i = 0; i < 4; i++) begin m_dx[i] = 0; m_dy[i] = 0; m_h[i] = 0; end
            m_sx = '0; m_sy = '0;
            return;
        end
        m_sx = mcells(m_px, m_dx);
        m_sy = mcells(m_py, m_dy);
        m_gnb = 0;
        if (!frame || busy || m_over) return;
        keys = '{krr, krl, kl, kr};
        if (m_wait) begin
            m_type = (np == 3'd7) ? 0 : int'(np);
            m_px = SX; m_py = 0;
            for (int i = 0; i < 4; i++) begin m_dx[i] = SDX[m_type][i]; m_dy[i] = SDY[m_type][i]; end
            m_wait = 0; m_loaded = 1; m_gnb = 1; m_g = 0;
            m_h = keys;
            return;
        end
        for (int i = 0; i < 4; i++) edg[i] = keys[i] && !m_h[i];
        m_h = keys;
        grav = (m_g == G - 1);
        act = -1;
        for (int i = 0; i < 4; i++) if (edg[i] && act < 0) act = i;
        if (act < 0 && (kd || grav)) act = 4;
        if (act == 4) m_g = 0;
        else if (!grav) m_g++;
        case (act)
            0: if (cm[2]) begin rotated(1, nx, ny); m_dx = nx; m_dy = ny; end
            1: if (cm[1]) begin rotated(0, nx, ny); m_dx = nx; m_dy = ny; end
            2: if (cm[4]) m_px = (m_px + 31) % 32;
            3: if (cm[3]) m_px = (m_px + 1) % 32;
            4: begin
                if (cm[0])         m_py = (m_py + 1) % 32;
                else if (m_py == 0) m_over = 1;
                else               m_wait = 1;
            end
            default: ;
        endcase
    endtask

    task automatic compare_model();
        int nx[4], ny[4];
        chk20("m_x_block", xb, mcells(m_px, m_dx));
        chk20("m_y_block", yb, mcells(m_py, m_dy));
        chk20("m_save_x", sxb, m_sx);
        chk20("m_save_y", syb, m_sy);
        chk1("m_get_new", gnb, m_gnb);
        chk1("m_game_over", gov, m_over);
        chk20("m_block", 20'(blk), m_loaded ? 20'(m_type + 1) : 20'd0);
        chk20("m_x_left", xml, m_loaded ? mcells((m_px + 31) % 32, m_dx) : 20'd0);
        chk20("m_x_right", xmr, m_loaded ? mcells((m_px + 1) % 32, m_dx) : 20'd0);
        chk20("m_y_down", ymd, m_loaded ? mcells((m_py + 1) % 32, m_dy) : 20'd0);
        rotated(1, nx, ny);
        chk20("m_x_rot_r", xrr, m_loaded ? mcells(m_px, nx) : 20'd0);
        chk20("m_y_rot_r", yrr, m_loaded ? mcells(m_py, ny) : 20'd0);
        rotated(0, nx, ny);
        chk20("m_y_rot_l", yrl, m_loaded ? mcells(m_py, ny) : 20'd0);
    endtask

    task automatic cycle();
        model_step();
        @(posedge Clk);
        #1;
        compare_model();
    endtask

    task automatic frames(input int n, input bit b);
        for (int i = 0; i < n; i++) begin
            frame = 1'b1; busy = b;
            cycle();
        end
        frame = 1'b0; busy = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          f;
        bit          b;
        bit [4:0]    k;     // {rot_r, rot_l, left, right, down}
        logic [19:0] ex, ey, esx, esy;
        bit          eg;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t v(input bit f, input bit b, input bit [4:0] k,
                               input logic [19:0] ex, input logic [19:0] ey,
                               input logic [19:0] esx, input logic [19:0] esy, input bit eg);
        vec_t r;
        r.f = f; r.b = b; r.k = k; r.ex = ex; r.ey = ey; r.esx = esx; r.esy = esy; r.eg = eg;
        return r;
    endfunction

    initial begin
        logic [19:0] A, L, R, Y0, Y1, Y2, Y3, YR, xo, yo;
        A  = pk4(4, 3, 4, 5); L  = pk4(3, 2, 3, 4); R  = pk4(5, 4, 4, 4);
        Y0 = pk4(0, 1, 1, 1); Y1 = pk4(1, 2, 2, 2); Y2 = pk4(2, 3, 3, 3);
        Y3 = pk4(3, 4, 4, 4); YR = pk4(4, 3, 4, 5);
        tbl.push_back(v(1, 0, 5'b00000, A, Y0, 20'd0, 20'd0, 1));
        tbl.push_back(v(0, 0, 5'b00000, A, Y0, A, Y0, 0));
        tbl.push_back(v(1, 0, 5'b00100, L, Y0, A, Y0, 0));
        tbl.push_back(v(0, 0, 5'b00100, L, Y0, L, Y0, 0));
        tbl.push_back(v(1, 0, 5'b00100, L, Y0, L, Y0, 0));
        tbl.push_back(v(1, 0, 5'b00010, A, Y0, L, Y0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(v(1, 0, 5'b00010, A, Y0, A, Y0, 0));
        tbl.push_back(v(1, 0, 5'b00001, A, Y1, A, Y0, 0));
        tbl.push_back(v(1, 0, 5'b00001, A, Y2, A, Y1, 0));
        tbl.push_back(v(1, 0, 5'b00001, A, Y3, A, Y2, 0));
        tbl.push_back(v(0, 0, 5'b00000, A, Y3, A, Y3, 0));
        tbl.push_back(v(1, 1, 5'b10000, A, Y3, A, Y3, 0));
        tbl.push_back(v(1, 0, 5'b10000, R, YR, A, Y3, 0));
        tbl.push_back(v(0, 0, 5'b00000, R, YR, R, YR, 0));

        // reset state
        Reset = 1'b1;
        cycle(); cycle();
        chk20("rst_x_block", xb, 20'd0);
        chk20("rst_y_block", yb, 20'd0);
        chk20("rst_x_move_left", xml, 20'd0);
        chk20("rst_block", 20'(blk), 20'd0);
        chk1("rst_get_new", gnb, 1'b0);
        chk1("rst_game_over", gov, 1'b0);
        Reset = 1'b0;

        // T spawn, left edge, held right, soft drop, busy-deferred rotate
        np = 3'd2; cm = 5'b11111;
        foreach (tbl[i]) begin
            frame = tbl[i].f; busy = tbl[i].b;
            {krr, krl, kl, kr, kd} = tbl[i].k;
            cycle();
            chk20($sformatf("tbl%0d_x", i), xb, tbl[i].ex);
            chk20($sformatf("tbl%0d_y", i), yb, tbl[i].ey);
            chk20($sformatf("tbl%0d_save_x", i), sxb, tbl[i].esx);
            chk20($sformatf("tbl%0d_save_y", i), syb, tbl[i].esy);
            chk1($sformatf("tbl%0d_get_new", i), gnb, tbl[i].eg);
        end
        {frame, busy, krr, krl, kl, kr, kd} = '0;

        // gravity timing, busy freeze, lock, respawn, game over
        Reset = 1'b1; cycle(); Reset = 1'b0;
        np = 3'd0;
        frames(1, 0);
        chk1("spawn_I_get_new", gnb, 1'b1);
        chk20("spawn_I_x", xb, pk4(3, 4, 5, 6));
        chk20("spawn_I_y", yb, pk4(1, 1, 1, 1));
        frames(29, 0);
        chk20("grav_29_hold", yb, pk4(1, 1, 1, 1));
        frames(1, 0);
        chk20("grav_30_step", yb, pk4(2, 2, 2, 2));
        frames(10, 0); frames(5, 1); cycle(); cycle(); frames(19, 0);
        chk20("grav_busy_hold", yb, pk4(2, 2, 2, 2));
        frames(1, 0);
        chk20("grav_busy_step", yb, pk4(3, 3, 3, 3));
        kd = 1'b1; frames(3, 0); kd = 1'b0;
        chk20("soft_drop_3", yb, pk4(6, 6, 6, 6));
        cm = 5'b11110;
        frames(30, 0);
        chk20("lock_y_hold", yb, pk4(6, 6, 6, 6));
        chk1("lock_no_game_over", gov, 1'b0);
        frames(1, 0);
        chk1("respawn_get_new", gnb, 1'b1);
        chk20("respawn_x", xb, pk4(3, 4, 5, 6));
        chk20("respawn_y", yb, pk4(1, 1, 1, 1));
        cycle();
        chk1("respawn_pulse_end", gnb, 1'b0);
        kd = 1'b1; frames(1, 0); kd = 1'b0;
        chk1("top_lock_game_over", gov, 1'b1);
        xo = xb; yo = yb;
        for (int i = 0; i < 40; i++) begin
            frame = 1'($urandom_range(0, 1));
            {krr, krl, kl, kr, kd} = 5'($urandom);
            np = 3'($urandom); cm = 5'($urandom);
            cycle();
            chk20("over_x_hold", xb, pk4(3, 4, 5, 6));
            chk20("over_y_hold", yb, pk4(1, 1, 1, 1));
            chk1("over_no_get_new", gnb, 1'b0);
            chk1("over_sticky", gov, 1'b1);
        end

        // randomized run against the model
        Reset = 1'b1; cycle(); Reset = 1'b0;
        {frame, busy, krr, krl, kl, kr, kd} = '0;
        for (int n = 0; n < 4000; n++) begin
            Reset = ($urandom_range(0, 299) == 0);
            frame = 1'($urandom_range(0, 1));
            busy  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) kl  = ~kl;
            if ($urandom_range(0, 3) == 0) kr  = ~kr;
            if ($urandom_range(0, 5) == 0) krl = ~krl;
            if ($urandom_range(0, 5) == 0) krr = ~krr;
            if ($urandom_range(0, 3) == 0) kd  = ~kd;
            np = 3'($urandom);
            for (int b = 0; b < 5; b++) cm[b] = ($urandom_range(0, 7) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
